mem_stage_lsu: RTL

- Memory-stage load/store unit for the 5-stage core.
- Consumes the EX/ME pipeline-register outputs: address, store data, load/store type and memory enables.
- Drives a single-outstanding request/response data-memory port, formats store data into byte lanes, and aligns and extends load data.
- Generates the pipeline stall that holds IF..ME while an access is in flight.

---
 rtl/mem_stage_lsu_if.sv | 19 +
 rtl/mem_stage_lsu.sv | 108 ++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: single-outstanding data-memory request/response port
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit with single-outstanding dmem port and pipeline stall
module mem_stage_lsu (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           ALU_result_M,
  input  logic [31:0]           write_data_M,
  input  logic [2:0]            ls_type_M,
  input  logic                  we_mem_M,
  input  logic                  re_mem_M,
  mem_stage_lsu_if.master       dmem,
  output logic [31:0]           mem_rdata_M,
  output logic                  stall_M,
  output logic                  lsu_fault_M
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0]  state_q, state_d, off_q, off_d;
  logic [2:0]  type_q, type_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        access, fault, start, capture;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt, st_data;
  logic [3:0]  st_strb;
  assign access = we_mem_M | re_mem_M;
  assign fault = (we_mem_M & re_mem_M)
               | (we_mem_M & (ls_type_M[2] | &ls_type_M[1:0]))
               | (re_mem_M & (ls_type_M == 3'b011 | &ls_type_M[2:1]))
               | (ls_type_M[1:0] == 2'b01 & ALU_result_M[0])
               | (ls_type_M == 3'b010 & |ALU_result_M[1:0]);
  assign start = state_q == IDLE & access & ~fault;
  assign capture = dmem.dmem_rvalid & ~we_q & ((state_q == BUSY & dmem.dmem_ready) | state_q == WAIT);
  assign lsu_fault_M = rst_n & state_q == IDLE & access & fault;
  assign stall_M = rst_n & (start | state_q == BUSY | state_q == WAIT);
  assign dmem.dmem_req = req_q;
  assign dmem.dmem_we = we_q;
  assign dmem.dmem_addr = addr_q;
  assign dmem.dmem_wstrb = wstrb_q;
  assign dmem.dmem_wdata = wdata_q;
  assign mem_rdata_M = rdata_q;
  // lane-replicate store data and build the byte-enable mask from the low address bits
  always_comb begin
    st_data = ls_type_M[1] ? write_data_M : ls_type_M[0] ? {2{write_data_M[15:0]}} : {4{write_data_M[7:0]}};
    st_strb = ls_type_M[1] ? 4'b1111 : (ls_type_M[0] ? 4'b0011 : 4'b0001) << ALU_result_M[1:0];
  end
  // pick the addressed byte/half of the returned word and sign- or zero-extend it
  always_comb begin
    ld_byte = dmem.dmem_rdata[8*off_q +: 8];
    ld_half = dmem.dmem_rdata[16*off_q[1] +: 16];
    ld_fmt = type_q[1] ? dmem.dmem_rdata
           : type_q[0] ? {{16{~type_q[2] & ld_half[15]}}, ld_half}
           : {{24{~type_q[2] & ld_byte[7]}}, ld_byte};
  end
  // request sequencing: issue from IDLE, hold until ready, wait for read data, one completion cycle
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    off_d = off_q;
    type_d = type_q;
    rdata_d = capture ? ld_fmt : rdata_q;
    if (start) begin
      state_d = BUSY;
      req_d = 1'b1;
      we_d = we_mem_M;
      addr_d = {ALU_result_M[31:2], 2'b00};
      wstrb_d = we_mem_M ? st_strb : 4'b0000;
      wdata_d = st_data;
      off_d = ALU_result_M[1:0];
      type_d = ls_type_M;
    end else if (state_q == BUSY && dmem.dmem_ready) begin
      req_d = 1'b0;
      state_d = (we_q | dmem.dmem_rvalid) ? DONE : WAIT;
    end else if (state_q == WAIT && dmem.dmem_rvalid) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state and port registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      off_q <= '0;
      type_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      off_q <= off_d;
      type_q <= type_d;
      rdata_q <= rdata_d;
    end
  end
endmodule
